// File: rtl/xosera_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xosera_pkg                                                       |
// | Shared types for the Xosera color-memory write path.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+

package xosera_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/color_wr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | color_wr_ctrl                                                    |
// | Fixed-priority arbiter (copper > CPU > block fill) for the single|
// | color memory write port. All outputs registered.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+

module color_wr_ctrl #(
   parameter int AWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              cop_wr_en_i,
   input  logic [AWIDTH-1:0] cop_addr_i,
   input  logic [15:0]       cop_data_i,
   input  logic              cpu_req_i,
   input  logic [AWIDTH-1:0] cpu_addr_i,
   input  logic [15:0]       cpu_data_i,
   output logic              cpu_ack_o,
   input  logic              fill_start_i,
   input  logic [AWIDTH-1:0] fill_base_i,
   input  logic [AWIDTH:0]   fill_count_i,
   input  logic [15:0]       fill_data_i,
   output logic              fill_busy_o,
   output logic              fill_done_o,
   output logic              col_wr_en_o,
   output logic [AWIDTH-1:0] col_wr_addr_o,
   output logic [15:0]       col_wr_data_o
);
   import xosera_pkg::*;

   localparam logic [AWIDTH-1:0] c_addr_one = {{(AWIDTH-1){1'b0}}, 1'b1};
   localparam logic [AWIDTH:0]   c_cnt_one  = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH:0]   c_cnt_zero = {(AWIDTH+1){1'b0}};
   localparam logic [AWIDTH:0]   c_fill_max = {1'b1, {AWIDTH{1'b0}}};

   fill_state_t       r_state, w_state_nxt;
   logic [AWIDTH-1:0] r_fill_addr, w_fill_addr_nxt;
   logic [AWIDTH:0]   r_fill_cnt, w_fill_cnt_nxt;
   logic [AWIDTH:0]   w_fill_cnt_clamp;
   logic [15:0]       r_fill_data, w_fill_data_nxt;
   logic              r_cpu_hold;
   logic              w_cpu_grant;
   logic              w_wr_en;
   logic [AWIDTH-1:0] w_wr_addr;
   logic [15:0]       w_wr_data;
   logic              w_cpu_ack;
   logic              w_fill_done;
   logic              w_fill_busy;

   // A request seen during reset must drop before it can be acked again.
   assign w_cpu_grant      = cpu_req_i && !cop_wr_en_i && !cpu_ack_o && !r_cpu_hold;
   assign w_fill_cnt_clamp = (fill_count_i > c_fill_max) ? c_fill_max : fill_count_i;

   always_comb begin
      w_state_nxt     = r_state;
      w_fill_addr_nxt = r_fill_addr;
      w_fill_cnt_nxt  = r_fill_cnt;
      w_fill_data_nxt = r_fill_data;
      w_wr_en         = 1'b0;
      w_wr_addr       = col_wr_addr_o;
      w_wr_data       = col_wr_data_o;
      w_cpu_ack       = 1'b0;
      w_fill_done     = 1'b0;
      w_fill_busy     = 1'b0;

      if (cop_wr_en_i) begin
         w_wr_en   = 1'b1;
         w_wr_addr = cop_addr_i;
         w_wr_data = cop_data_i;
      end else if (w_cpu_grant) begin
         w_wr_en   = 1'b1;
         w_wr_addr = cpu_addr_i;
         w_wr_data = cpu_data_i;
         w_cpu_ack = 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (fill_start_i) begin
               w_fill_addr_nxt = fill_base_i;
               w_fill_data_nxt = fill_data_i;
               w_fill_cnt_nxt  = w_fill_cnt_clamp;
               if (w_fill_cnt_clamp == c_cnt_zero) begin
                  w_fill_done = 1'b1;
               end else begin
                  w_state_nxt = FILL;
                  w_fill_busy = 1'b1;
               end
            end
         end
         FILL: begin
            w_fill_busy = 1'b1;
            // Fill only takes slots the copper and CPU leave free.
            if (!cop_wr_en_i && !w_cpu_grant) begin
               w_wr_en         = 1'b1;
               w_wr_addr       = r_fill_addr;
               w_wr_data       = r_fill_data;
               w_fill_addr_nxt = r_fill_addr + c_addr_one;
               w_fill_cnt_nxt  = r_fill_cnt - c_cnt_one;
               if (r_fill_cnt == c_cnt_one) begin
                  w_fill_done = 1'b1;
                  w_fill_busy = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state       <= IDLE;
         r_fill_addr   <= '0;
         r_fill_cnt    <= '0;
         r_fill_data   <= '0;
         r_cpu_hold    <= 1'b1;
         cpu_ack_o     <= 1'b0;
         fill_busy_o   <= 1'b0;
         fill_done_o   <= 1'b0;
         col_wr_en_o   <= 1'b0;
         col_wr_addr_o <= '0;
         col_wr_data_o <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_fill_addr   <= w_fill_addr_nxt;
         r_fill_cnt    <= w_fill_cnt_nxt;
         r_fill_data   <= w_fill_data_nxt;
         if (!cpu_req_i) begin
            r_cpu_hold <= 1'b0;
         end
         cpu_ack_o     <= w_cpu_ack;
         fill_busy_o   <= w_fill_busy;
         fill_done_o   <= w_fill_done;
         col_wr_en_o   <= w_wr_en;
         col_wr_addr_o <= w_wr_addr;
         col_wr_data_o <= w_wr_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_color_wr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_color_wr_ctrl                                                 |
// | Directed scoreboard bench for color_wr_ctrl.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+

module tb_color_wr_ctrl;

   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
      logic          ack;
      logic          done;
   } wr_exp_t;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          cop_wr_en_i;
   logic [AW-1:0] cop_addr_i;
   logic [15:0]   cop_data_i;
   logic          cpu_req_i;
   logic [AW-1:0] cpu_addr_i;
   logic [15:0]   cpu_data_i;
   logic          cpu_ack_o;
   logic          fill_start_i;
   logic [AW-1:0] fill_base_i;
   logic [AW:0]   fill_count_i;
   logic [15:0]   fill_data_i;
   logic          fill_busy_o;
   logic          fill_done_o;
   logic          col_wr_en_o;
   logic [AW-1:0] col_wr_addr_o;
   logic [15:0]   col_wr_data_o;

   wr_exp_t sb[$];
   int      total = 0;
   int      bad   = 0;

   always #5 clk = ~clk;

   color_wr_ctrl #(.AWIDTH(AW)) dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .cop_wr_en_i   (cop_wr_en_i),
      .cop_addr_i    (cop_addr_i),
      .cop_data_i    (cop_data_i),
      .cpu_req_i     (cpu_req_i),
      .cpu_addr_i    (cpu_addr_i),
      .cpu_data_i    (cpu_data_i),
      .cpu_ack_o     (cpu_ack_o),
      .fill_start_i  (fill_start_i),
      .fill_base_i   (fill_base_i),
      .fill_count_i  (fill_count_i),
      .fill_data_i   (fill_data_i),
      .fill_busy_o   (fill_busy_o),
      .fill_done_o   (fill_done_o),
      .col_wr_en_o   (col_wr_en_o),
      .col_wr_addr_o (col_wr_addr_o),
      .col_wr_data_o (col_wr_data_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [15:0] d,
                       input logic ack, input logic done);
      wr_exp_t e;
      e.addr = a;
      e.data = d;
      e.ack  = ack;
      e.done = done;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Every write on the port must match the next scoreboard entry.
   always @(negedge clk) begin
      if (col_wr_en_o === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
                   col_wr_addr_o, col_wr_data_o);
         end else begin
            wr_exp_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(col_wr_addr_o), 32'(e.addr));
            check("wr_data", 32'(col_wr_data_o), 32'(e.data));
            check("wr_ack",  32'(cpu_ack_o),     32'(e.ack));
            check("wr_done", 32'(fill_done_o),   32'(e.done));
         end
      end else begin
         check("ack_without_write", 32'(cpu_ack_o), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i      = 1'b1;
      cop_wr_en_i  = 1'b0;
      cop_addr_i   = '0;
      cop_data_i   = '0;
      cpu_req_i    = 1'b0;
      cpu_addr_i   = '0;
      cpu_data_i   = '0;
      fill_start_i = 1'b0;
      fill_base_i  = '0;
      fill_count_i = '0;
      fill_data_i  = '0;

      repeat (2) cyc();
      check("rst_wr_en",   32'(col_wr_en_o),   32'd0);
      check("rst_wr_addr", 32'(col_wr_addr_o), 32'd0);
      check("rst_wr_data", 32'(col_wr_data_o), 32'd0);
      check("rst_ack",     32'(cpu_ack_o),     32'd0);
      check("rst_busy",    32'(fill_busy_o),   32'd0);
      check("rst_done",    32'(fill_done_o),   32'd0);
      reset_i = 1'b0;
      cyc();

      // CPU-only write; request deliberately held through the ack cycle
      cpu_req_i  = 1'b1;
      cpu_addr_i = 8'h10;
      cpu_data_i = 16'h0F0F;
      push(8'h10, 16'h0F0F, 1'b1, 1'b0);
      cyc();
      check("s1_ack", 32'(cpu_ack_o), 32'd1);
      cyc();
      check("s1_single_write", 32'(col_wr_en_o), 32'd0);
      cpu_req_i = 1'b0;
      cyc();

      // Copper beats CPU
      cop_wr_en_i = 1'b1;
      cop_addr_i  = 8'h20;
      cop_data_i  = 16'h1234;
      cpu_req_i   = 1'b1;
      cpu_addr_i  = 8'h21;
      cpu_data_i  = 16'hABCD;
      push(8'h20, 16'h1234, 1'b0, 1'b0);
      cyc();
      check("s2_no_ack_on_cop", 32'(cpu_ack_o), 32'd0);
      cop_wr_en_i = 1'b0;
      push(8'h21, 16'hABCD, 1'b1, 1'b0);
      cyc();
      check("s2_cpu_ack", 32'(cpu_ack_o), 32'd1);
      cpu_req_i = 1'b0;
      cyc();
      check("s2_idle", 32'(col_wr_en_o), 32'd0);

      // Fill with address wrap
      fill_start_i = 1'b1;
      fill_base_i  = 8'hFE;
      fill_count_i = 9'd4;
      fill_data_i  = 16'h0777;
      push(8'hFE, 16'h0777, 1'b0, 1'b0);
      push(8'hFF, 16'h0777, 1'b0, 1'b0);
      push(8'h00, 16'h0777, 1'b0, 1'b0);
      push(8'h01, 16'h0777, 1'b0, 1'b1);
      cyc();
      fill_start_i = 1'b0;
      check("s3_busy_start", 32'(fill_busy_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("s3_busy", 32'(fill_busy_o), (i < 3) ? 32'd1 : 32'd0);
      end
      cyc();
      check("s3_done_cleared", 32'(fill_done_o), 32'd0);
      check("s3_sb_empty", 32'(sb.size()), 32'd0);

      // Fill preempted by copper every other cycle
      fill_start_i = 1'b1;
      fill_base_i  = 8'h40;
      fill_count_i = 9'd8;
      fill_data_i  = 16'h5A5A;
      cyc();
      fill_start_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("s4_busy", 32'(fill_busy_o), 32'd1);
         if (i % 2 == 0) begin
            cop_wr_en_i = 1'b1;
            cop_addr_i  = AW'(8'h80 + i);
            cop_data_i  = 16'(16'hC000 + i);
            push(AW'(8'h80 + i), 16'(16'hC000 + i), 1'b0, 1'b0);
         end else begin
            cop_wr_en_i = 1'b0;
            push(AW'(8'h40 + i / 2), 16'h5A5A, 1'b0, (i == 15));
         end
         cyc();
      end
      cop_wr_en_i = 1'b0;
      check("s4_done_busy", 32'(fill_busy_o), 32'd0);
      cyc();
      check("s4_idle", 32'(col_wr_en_o), 32'd0);
      check("s4_sb_empty", 32'(sb.size()), 32'd0);

      // Zero-length fill
      fill_start_i = 1'b1;
      fill_count_i = 9'd0;
      fill_base_i  = 8'h33;
      cyc();
      fill_start_i = 1'b0;
      check("s5_zero_done", 32'(fill_done_o), 32'd1);
      check("s5_zero_busy", 32'(fill_busy_o), 32'd0);
      check("s5_zero_nowr", 32'(col_wr_en_o), 32'd0);
      cyc();
      check("s5_zero_done_clr", 32'(fill_done_o), 32'd0);

      // Oversized fill clamps to full memory; restart on the done cycle
      fill_start_i = 1'b1;
      fill_count_i = 9'h1FF;
      fill_base_i  = 8'h00;
      fill_data_i  = 16'h1111;
      for (int i = 0; i < 256; i++) begin
         push(AW'(i), 16'h1111, 1'b0, (i == 255));
      end
      cyc();
      fill_start_i = 1'b0;
      repeat (256) cyc();
      check("s5_full_busy_off", 32'(fill_busy_o), 32'd0);
      fill_start_i = 1'b1;
      fill_base_i  = 8'h10;
      fill_count_i = 9'd2;
      fill_data_i  = 16'h2222;
      push(8'h10, 16'h2222, 1'b0, 1'b0);
      push(8'h11, 16'h2222, 1'b0, 1'b1);
      cyc();
      fill_start_i = 1'b0;
      check("s5_restart_busy", 32'(fill_busy_o), 32'd1);
      repeat (2) cyc();
      cyc();
      check("s5_restart_idle", 32'(fill_busy_o), 32'd0);
      check("s5_sb_empty", 32'(sb.size()), 32'd0);

      // Reset in the third fill cycle, CPU request pending across reset
      fill_start_i = 1'b1;
      fill_base_i  = 8'h30;
      fill_count_i = 9'd8;
      fill_data_i  = 16'h3333;
      push(8'h30, 16'h3333, 1'b0, 1'b0);
      push(8'h31, 16'h3333, 1'b0, 1'b0);
      cyc();
      fill_start_i = 1'b0;
      repeat (2) cyc();
      reset_i    = 1'b1;
      cpu_req_i  = 1'b1;
      cpu_addr_i = 8'h55;
      cpu_data_i = 16'h5555;
      cyc();
      check("s6_rst_wr_en", 32'(col_wr_en_o), 32'd0);
      check("s6_rst_busy",  32'(fill_busy_o), 32'd0);
      check("s6_rst_done",  32'(fill_done_o), 32'd0);
      reset_i = 1'b0;
      cyc();
      check("s6_no_ack_held", 32'(cpu_ack_o), 32'd0);
      check("s6_no_done",     32'(fill_done_o), 32'd0);
      cyc();
      check("s6_no_ack_held2", 32'(cpu_ack_o), 32'd0);
      cpu_req_i = 1'b0;
      cyc();
      cpu_req_i = 1'b1;
      push(8'h55, 16'h5555, 1'b1, 1'b0);
      cyc();
      check("s6_ack_after_represent", 32'(cpu_ack_o), 32'd1);
      cpu_req_i = 1'b0;
      cyc();
      check("s6_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
